// File: rtl/stream_arb_mux.sv
// N-channel registered stream multiplexer with built-in arbitration.
// Packets are atomic: a channel keeps the grant from its first beat until its last.
module stream_arb_mux #(
  parameter  int N       = 4,
  parameter  int WIDTH   = 32,
  parameter  int RR_MODE = 1,
  localparam int SELW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             r_lock;
  logic [SELW-1:0]  r_lock_ch;
  logic [SELW-1:0]  r_rr_ptr;

  logic [SELW-1:0]  w_grant;
  logic [SELW-1:0]  w_next_ptr;
  logic             w_load_en;
  logic             w_gvalid;
  logic             w_glast;
  logic [WIDTH-1:0] w_gdata;
  logic             w_xfer;

  // Descending search so the final assignment is the first hit from the start point.
  always_comb begin
    w_grant = '0;
    if (r_lock) begin
      w_grant = r_lock_ch;
    end else if (RR_MODE != 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[(int'(r_rr_ptr) + k) % N]) begin
          w_grant = SELW'((int'(r_rr_ptr) + k) % N);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[k]) begin
          w_grant = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    w_gvalid = 1'b0;
    w_glast  = 1'b0;
    w_gdata  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SELW'(i)) begin
        w_gvalid = in_valid[i];
        w_glast  = in_last[i];
        w_gdata  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign w_load_en = rst_n && (!out_valid || out_ready);
  assign w_xfer    = w_load_en && w_gvalid;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = w_load_en && (w_grant == SELW'(i)) && (r_lock || w_gvalid);
    end
  end

  assign w_next_ptr = (int'(w_grant) == N - 1) ? '0 : w_grant + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
      r_rr_ptr  <= '0;
    end else if (w_xfer) begin
      out_valid <= 1'b1;
      out_data  <= w_gdata;
      out_last  <= w_glast;
      out_sel   <= w_grant;
      r_lock    <= !w_glast;
      if (!w_glast) begin
        r_lock_ch <= w_grant;
      end else if (RR_MODE != 0) begin
        r_rr_ptr <= w_next_ptr;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Drives a fixed-priority and a round-robin instance with shared stimulus and
// compares both against a packet-level arbitration model every cycle.
module tb_stream_arb_mux;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_last = '0;
  logic           out_ready = 1'b0;

  logic [N-1:0]   rdy [2];
  logic [W-1:0]   od  [2];
  logic           ol  [2];
  logic [1:0]     os  [2];
  logic           ov  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_arb_mux #(.N(N), .WIDTH(W), .RR_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy[0]), .out_data(od[0]), .out_last(ol[0]),
    .out_sel(os[0]), .out_valid(ov[0]), .out_ready(out_ready));

  stream_arb_mux #(.N(N), .WIDTH(W), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy[1]), .out_data(od[1]), .out_last(ol[1]),
    .out_sel(os[1]), .out_valid(ov[1]), .out_ready(out_ready));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model state: what the output register holds and which packet owns the grant.
  bit       m_v    [2] = '{0, 0};
  bit [31:0] m_d   [2] = '{0, 0};
  bit       m_l    [2] = '{0, 0};
  int       m_s    [2] = '{0, 0};
  bit       m_lock [2] = '{0, 0};
  int       m_lch  [2] = '{0, 0};
  int       m_ptr  [2] = '{0, 0};

  function automatic int arb(input logic [N-1:0] v, input bit rr, input int ptr);
    for (int k = 0; k < N; k++) begin
      int c;
      c = rr ? (ptr + k) % N : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!rst_n) begin
          m_v[m] = 0; m_d[m] = 0; m_l[m] = 0; m_s[m] = 0;
          m_lock[m] = 0; m_lch[m] = 0; m_ptr[m] = 0;
          chk($sformatf("m%0d rst valid", m), 64'(ov[m]), 64'(0));
          chk($sformatf("m%0d rst ready", m), 64'(rdy[m]), 64'(0));
          chk($sformatf("m%0d rst data", m), 64'(od[m]), 64'(0));
        end else begin
          int g;
          bit le;
          logic [N-1:0] er;
          g  = m_lock[m] ? m_lch[m] : arb(in_valid, m == 1, m_ptr[m]);
          le = !m_v[m] || out_ready;
          er = '0;
          if (le && g >= 0 && (m_lock[m] || in_valid[g])) er[g] = 1'b1;
          chk($sformatf("m%0d valid", m), 64'(ov[m]), 64'(m_v[m]));
          chk($sformatf("m%0d data", m), 64'(od[m]), 64'(m_d[m]));
          chk($sformatf("m%0d last", m), 64'(ol[m]), 64'(m_l[m]));
          chk($sformatf("m%0d sel", m), 64'(os[m]), 64'(m_s[m]));
          chk($sformatf("m%0d in_ready", m), 64'(rdy[m]), 64'(er));
          if (le && g >= 0 && in_valid[g]) begin
            m_v[m] = 1;
            m_d[m] = in_data[g*W +: W];
            m_l[m] = in_last[g];
            m_s[m] = g;
            if (in_last[g]) begin
              m_lock[m] = 0;
              if (m == 1) m_ptr[m] = (g + 1) % N;
            end else begin
              m_lock[m] = 1;
              m_lch[m]  = g;
            end
          end else if (m_v[m] && out_ready) begin
            m_v[m] = 0;
          end
        end
      end
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [31:0] d, input bit v, input bit l);
    in_data[c*W +: W] = d;
    in_valid[c] = v;
    in_last[c] = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    edge1();
    edge1();
    rst_n = 1'b1;
  endtask

  int exp_rr [5] = '{0, 1, 2, 3, 0};
  logic [31:0] q [$];
  logic [31:0] held;

  initial begin
    // Valid inputs during reset must not see in_ready.
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    edge1();
    #1;
    chk("lit rst in_ready", 64'(rdy[1]), 64'(0));
    chk("lit rst out_valid", 64'(ov[1]), 64'(0));
    edge1();
    in_valid = '0;
    rst_n = 1'b1;

    // Single beat on ch2.
    out_ready = 1'b1;
    set_ch(2, 32'hDEADBEEF, 1'b1, 1'b1);
    #1;
    chk("lit ch2 in_ready", 64'(rdy[1]), 64'(4'b0100));
    edge1();
    in_valid = '0;
    #1;
    chk("lit ch2 valid", 64'(ov[1]), 64'(1));
    chk("lit ch2 data", 64'(od[1]), 64'(32'hDEADBEEF));
    chk("lit ch2 sel", 64'(os[1]), 64'(2));
    chk("lit ch2 last", 64'(ol[1]), 64'(1));

    // Round-robin rotation with all channels presenting single-beat packets.
    do_reset();
    for (int i = 0; i < N; i++) set_ch(i, 32'h10 + 32'(i), 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      edge1();
      chk($sformatf("lit rr sel %0d", k), 64'(os[1]), 64'(exp_rr[k]));
      chk($sformatf("lit rr valid %0d", k), 64'(ov[1]), 64'(1));
    end

    // Fixed priority: ch1 beats ch3 every cycle.
    do_reset();
    in_valid = 4'b1010;
    in_last  = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("lit fp ready3 %0d", k), 64'(rdy[0][3]), 64'(0));
      edge1();
      chk($sformatf("lit fp sel %0d", k), 64'(os[0]), 64'(1));
    end

    // Three-beat ch0 packet with a two-cycle stall; ch1 waits it out.
    do_reset();
    q.delete();
    set_ch(1, 32'hA1, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: set_ch(0, 32'h1, 1'b1, 1'b0);
        1: set_ch(0, 32'h2, 1'b1, 1'b0);
        2, 3: set_ch(0, 32'h0, 1'b0, 1'b0);
        4: set_ch(0, 32'h3, 1'b1, 1'b1);
        default: set_ch(0, 32'h0, 1'b0, 1'b0);
      endcase
      #1;
      if (k < 5) chk($sformatf("lit pkt ready1 %0d", k), 64'(rdy[1][1]), 64'(0));
      else       chk("lit pkt ready after", 64'(rdy[1]), 64'(4'b0010));
      edge1();
      if (ov[1]) q.push_back(od[1]);
    end
    in_valid = '0;
    chk("lit pkt count", 64'(q.size()), 64'(4));
    if (q.size() == 4) begin
      chk("lit pkt b0", 64'(q[0]), 64'(32'h1));
      chk("lit pkt b1", 64'(q[1]), 64'(32'h2));
      chk("lit pkt b2", 64'(q[2]), 64'(32'h3));
      chk("lit pkt b3", 64'(q[3]), 64'(32'hA1));
    end

    // Backpressure: rr pointer is now 2, so ch2 loads then ch3 follows.
    for (int i = 0; i < N; i++) set_ch(i, 32'h100 + 32'(i), 1'b1, 1'b1);
    edge1();
    out_ready = 1'b0;
    held = od[1];
    chk("lit bp first", 64'(held), 64'(32'h102));
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("lit bp ready %0d", k), 64'(rdy[1]), 64'(0));
      edge1();
      chk($sformatf("lit bp data %0d", k), 64'(od[1]), 64'(held));
    end
    out_ready = 1'b1;
    #1;
    chk("lit bp release ready", 64'(rdy[1]), 64'(4'b1000));
    edge1();
    chk("lit bp next data", 64'(od[1]), 64'(32'h103));
    chk("lit bp next valid", 64'(ov[1]), 64'(1));

    // Asynchronous reset mid-packet.
    in_valid = '0;
    set_ch(0, 32'h55, 1'b1, 1'b0);
    edge1();
    in_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit arst valid", 64'(ov[1]), 64'(0));
    chk("lit arst ready", 64'(rdy[1]), 64'(0));
    edge1();
    edge1();
    rst_n = 1'b1;
    set_ch(2, 32'h77, 1'b1, 1'b1);
    #1;
    chk("lit arst ch2 ready rr", 64'(rdy[1]), 64'(4'b0100));
    chk("lit arst ch2 ready fp", 64'(rdy[0]), 64'(4'b0100));
    edge1();
    in_valid = '0;
    chk("lit arst sel", 64'(os[1]), 64'(2));
    chk("lit arst data", 64'(od[1]), 64'(32'h77));

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        set_ch(i, $urandom, ($urandom_range(0, 99) < 60), ($urandom_range(0, 2) == 0));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      edge1();
    end

    in_valid = '0;
    edge1();
    edge1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
